// File: rtl/int8_mac_result_buffer.sv
// Result buffer behind int8_mac_unit: in-order FIFO of result beats with a
// valid/ready output and a credit-based issue-side ready that reserves a slot per instruction.
module int8_mac_result_buffer #(
    parameter int  XLEN     = 32,
    parameter int  DEPTH    = 4,
    parameter type hartid_t = logic [1:0],
    parameter type id_t     = logic [2:0]
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       issue_valid_i,
    output logic                       issue_ready_o,
    input  logic                       mac_valid_i,
    input  logic                       mac_we_i,
    input  logic [XLEN-1:0]            mac_result_i,
    input  logic [4:0]                 mac_rd_addr_i,
    input  hartid_t                    mac_hartid_i,
    input  id_t                        mac_id_i,
    output logic                       result_valid_o,
    input  logic                       result_ready_i,
    output logic [XLEN-1:0]            result_data_o,
    output logic                       result_we_o,
    output logic [4:0]                 result_rd_o,
    output hartid_t                    result_hartid_o,
    output id_t                        result_id_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       overflow_o
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    typedef struct packed {
        logic            we;
        logic [XLEN-1:0] data;
        logic [4:0]      rd;
        hartid_t         hartid;
        id_t             id;
    } entry_t;

    entry_t        mem_q [DEPTH];
    entry_t        head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic          overflow_q, overflow_d;
    logic [CW:0]   occupancy;
    logic          pop, push, issue_fire;

    function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] ptr);
        return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    endfunction

    // A pop frees the head slot, so a full buffer can still accept a beat that cycle.
    assign pop        = (count_q != '0) && result_ready_i;
    assign push       = mac_valid_i && ((count_q != CW'(DEPTH)) || pop);
    assign occupancy  = {1'b0, count_q} + {1'b0, inflight_q};
    assign issue_ready_o = occupancy < (CW + 1)'(DEPTH);
    assign issue_fire = issue_valid_i && issue_ready_o;

    // NOTE: every next-state signal gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d    = count_q;
        inflight_d = inflight_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q || (mac_valid_i && !push);
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
        if (push) wr_ptr_d = next_ptr(wr_ptr_q);
        if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
        if (issue_fire && !mac_valid_i) begin
            inflight_d = inflight_q + CW'(1);
        end else if (mac_valid_i && !issue_fire && (inflight_q != '0)) begin
            inflight_d = inflight_q - CW'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q    <= '0;
            inflight_q <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is reset on purpose so the head outputs read as zero after reset; this costs flops, not a RAM macro.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push) begin
            mem_q[wr_ptr_q] <= '{we: mac_we_i, data: mac_result_i, rd: mac_rd_addr_i,
                                 hartid: mac_hartid_i, id: mac_id_i};
        end
    end

    assign head            = mem_q[rd_ptr_q];
    assign result_valid_o  = (count_q != '0);
    assign result_data_o   = head.data;
    assign result_we_o     = head.we;
    assign result_rd_o     = head.rd;
    assign result_hartid_o = head.hartid;
    assign result_id_o     = head.id;
    assign count_o         = count_q;
    assign overflow_o      = overflow_q;
endmodule

// File: tb/tb_int8_mac_result_buffer.sv
// Directed self-checking bench for int8_mac_result_buffer (DEPTH=4, XLEN=32).
module tb_int8_mac_result_buffer;
    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        issue_valid_i = 1'b0;
    logic        issue_ready_o;
    logic        mac_valid_i = 1'b0;
    logic        mac_we_i = 1'b0;
    logic [31:0] mac_result_i = '0;
    logic [4:0]  mac_rd_addr_i = '0;
    logic [1:0]  mac_hartid_i = '0;
    logic [2:0]  mac_id_i = '0;
    logic        result_valid_o;
    logic        result_ready_i = 1'b0;
    logic [31:0] result_data_o;
    logic        result_we_o;
    logic [4:0]  result_rd_o;
    logic [1:0]  result_hartid_o;
    logic [2:0]  result_id_o;
    logic [2:0]  count_o;
    logic        overflow_o;

    int checks = 0;
    int errors = 0;

    int8_mac_result_buffer #(.XLEN(32), .DEPTH(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .issue_valid_i(issue_valid_i), .issue_ready_o(issue_ready_o),
        .mac_valid_i(mac_valid_i), .mac_we_i(mac_we_i), .mac_result_i(mac_result_i),
        .mac_rd_addr_i(mac_rd_addr_i), .mac_hartid_i(mac_hartid_i), .mac_id_i(mac_id_i),
        .result_valid_o(result_valid_o), .result_ready_i(result_ready_i),
        .result_data_o(result_data_o), .result_we_o(result_we_o), .result_rd_o(result_rd_o),
        .result_hartid_o(result_hartid_o), .result_id_o(result_id_o),
        .count_o(count_o), .overflow_o(overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Advance past one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic cycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic push_beat(input logic [31:0] data, input logic we, input logic [4:0] rd,
                             input logic [1:0] hart, input logic [2:0] id);
        mac_valid_i   = 1'b1;
        mac_result_i  = data;
        mac_we_i      = we;
        mac_rd_addr_i = rd;
        mac_hartid_i  = hart;
        mac_id_i      = id;
        cycle();
        mac_valid_i   = 1'b0;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        repeat (2) cycle();
        checks++;
        if (result_valid_o !== 1'b0 || count_o !== 3'd0 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%b count=%0d ovf=%b required 0/0/0",
                     result_valid_o, count_o, overflow_o);
        end
        checks++;
        if (result_data_o !== 32'd0 || result_we_o !== 1'b0 || result_rd_o !== 5'd0 ||
            result_hartid_o !== 2'd0 || result_id_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_head: data=%0h we=%b rd=%0d hart=%0d id=%0d required all 0",
                     result_data_o, result_we_o, result_rd_o, result_hartid_o, result_id_o);
        end
        rst_ni = 1'b1;
        cycle();
        checks++;
        if (issue_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_issue_ready: got %b required 1", issue_ready_o);
        end
    endtask

    task automatic test_single_beat();
        result_ready_i = 1'b1;
        push_beat(32'd25, 1'b1, 5'd5, 2'd1, 3'd1);
        checks++;
        if (result_valid_o !== 1'b1 || result_data_o !== 32'd25 || result_we_o !== 1'b1 ||
            result_rd_o !== 5'd5 || result_hartid_o !== 2'd1 || result_id_o !== 3'd1) begin
            errors++;
            $display("FAIL single_head: valid=%b data=%0d we=%b rd=%0d hart=%0d id=%0d required 1/25/1/5/1/1",
                     result_valid_o, result_data_o, result_we_o, result_rd_o, result_hartid_o, result_id_o);
        end
        cycle();
        checks++;
        if (count_o !== 3'd0 || result_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL single_drain: count=%0d valid=%b required 0/0", count_o, result_valid_o);
        end
        result_ready_i = 1'b0;
    endtask

    task automatic test_fifo_order();
        logic [31:0] vals [4];
        vals = '{32'd100, 32'd200, 32'd221, 32'hFFFF_FFF1};
        result_ready_i = 1'b0;
        for (int i = 0; i < 4; i++) push_beat(vals[i], 1'b0, 5'(i + 8), 2'(i), 3'(i));
        checks++;
        if (count_o !== 3'd4 || issue_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL fifo_full: count=%0d issue_ready=%b required 4/0", count_o, issue_ready_o);
        end
        cycle();
        checks++;
        if (result_data_o !== 32'd100 || result_we_o !== 1'b0 || result_rd_o !== 5'd8) begin
            errors++;
            $display("FAIL fifo_hold: data=%0d we=%b rd=%0d required 100/0/8",
                     result_data_o, result_we_o, result_rd_o);
        end
        result_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (result_valid_o !== 1'b1 || result_data_o !== vals[i] || result_rd_o !== 5'(i + 8)) begin
                errors++;
                $display("FAIL fifo_order[%0d]: data=%0h rd=%0d required %0h/%0d",
                         i, result_data_o, result_rd_o, vals[i], i + 8);
            end
            cycle();
        end
        checks++;
        if (count_o !== 3'd0 || result_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL fifo_empty: count=%0d valid=%b required 0/0", count_o, result_valid_o);
        end
        result_ready_i = 1'b0;
    endtask

    task automatic test_full_push_pop();
        logic [31:0] vals [4];
        vals = '{32'd2, 32'd3, 32'd4, 32'd127};
        for (int i = 1; i <= 4; i++) push_beat(32'(i), 1'b1, 5'd1, 2'd0, 3'd0);
        result_ready_i = 1'b1;
        push_beat(32'd127, 1'b1, 5'd2, 2'd3, 3'd7);
        checks++;
        if (count_o !== 3'd4 || overflow_o !== 1'b0) begin
            errors++;
            $display("FAIL full_push_pop: count=%0d ovf=%b required 4/0", count_o, overflow_o);
        end
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (result_data_o !== vals[i]) begin
                errors++;
                $display("FAIL full_push_pop_order[%0d]: got %0d required %0d", i, result_data_o, vals[i]);
            end
            cycle();
        end
        checks++;
        if (count_o !== 3'd0) begin
            errors++;
            $display("FAIL full_push_pop_empty: count=%0d required 0", count_o);
        end
        result_ready_i = 1'b0;
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 4; i++) push_beat(32'(10 + i), 1'b1, 5'd3, 2'd0, 3'd0);
        push_beat(32'hFFFF_FF80, 1'b1, 5'd4, 2'd0, 3'd0);
        checks++;
        if (count_o !== 3'd4 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: count=%0d ovf=%b required 4/1", count_o, overflow_o);
        end
        result_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (result_data_o !== 32'(10 + i)) begin
                errors++;
                $display("FAIL overflow_drain[%0d]: got %0h required %0h", i, result_data_o, 10 + i);
            end
            cycle();
        end
        checks++;
        if (count_o !== 3'd0 || result_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: count=%0d valid=%b ovf=%b required 0/0/1",
                     count_o, result_valid_o, overflow_o);
        end
        result_ready_i = 1'b0;
    endtask

    task automatic test_credit();
        push_beat(32'd50, 1'b1, 5'd6, 2'd2, 3'd2);
        issue_valid_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            checks++;
            if (issue_ready_o !== (i < 2)) begin
                errors++;
                $display("FAIL credit_fire[%0d]: issue_ready=%b required %b", i, issue_ready_o, i < 2);
            end
        end
        issue_valid_i = 1'b0;
        push_beat(32'd51, 1'b1, 5'd7, 2'd2, 3'd3);
        checks++;
        if (issue_ready_o !== 1'b0 || count_o !== 3'd2) begin
            errors++;
            $display("FAIL credit_mac: issue_ready=%b count=%0d required 0/2", issue_ready_o, count_o);
        end
        result_ready_i = 1'b1;
        cycle();
        result_ready_i = 1'b0;
        checks++;
        if (issue_ready_o !== 1'b1 || count_o !== 3'd1 || result_data_o !== 32'd51) begin
            errors++;
            $display("FAIL credit_restore: issue_ready=%b count=%0d data=%0d required 1/1/51",
                     issue_ready_o, count_o, result_data_o);
        end
    endtask

    task automatic test_reset_mid();
        push_beat(32'd60, 1'b1, 5'd9, 2'd0, 3'd4);
        push_beat(32'd61, 1'b1, 5'd9, 2'd0, 3'd5);
        checks++;
        if (count_o !== 3'd3 || overflow_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset: count=%0d ovf=%b required 3/1", count_o, overflow_o);
        end
        #2 rst_ni = 1'b0;
        #1;
        checks++;
        if (result_valid_o !== 1'b0 || count_o !== 3'd0 || overflow_o !== 1'b0 ||
            result_data_o !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: valid=%b count=%0d ovf=%b data=%0h required 0/0/0/0",
                     result_valid_o, count_o, overflow_o, result_data_o);
        end
        cycle();
        rst_ni = 1'b1;
        cycle();
        checks++;
        if (issue_ready_o !== 1'b1 || count_o !== 3'd0) begin
            errors++;
            $display("FAIL post_reset: issue_ready=%b count=%0d required 1/0", issue_ready_o, count_o);
        end
    endtask

    initial begin
        test_reset();
        test_single_beat();
        test_fifo_order();
        test_full_push_pop();
        test_overflow();
        test_credit();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
